// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Reader side of program_rom. Owns the program counter, drives the ROM
//   address and captures each fetched word into a one-entry output stage
//   that is handed to the decoder over a valid/ready handshake. Supports
//   redirect (jump/branch) and halt.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   run           fetch enable
//   rom_addr      address to program_rom (the pc register)
//   rom_data      combinational read data from program_rom
//   inst          registered instruction to the decoder
//   inst_pc       address inst was fetched from
//   inst_valid    inst/inst_pc hold a valid word
//   inst_ready    decoder accepts the word this cycle
//   redirect      load redirect_pc and flush the output stage
//   redirect_pc   redirect target
//   halted        high while in the HALTED state
//   fetch_count   words accepted by the decoder, saturating
module instr_fetch_unit #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned INST_W  = 16,
  parameter logic [3:0]  HALT_OP = 4'b1110,
  parameter bit          WRAP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  localparam int unsigned CNT_W = 16;
  localparam logic [ADDR_W-1:0] PC_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
  logic                inst_valid_q, inst_valid_d;
  logic                halted_q, halted_d;
  logic [CNT_W-1:0]    fetch_count_q, fetch_count_d;

  logic                xfer_c;
  logic                load_c;
  logic                last_addr_c;
  logic                halt_hit_c;

  // Next-state and datapath: redirect overrides everything, otherwise a
  // load happens whenever fetching is allowed and the output slot is free.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;

    xfer_c      = inst_valid_q && inst_ready;
    // IDLE with run high loads on the same edge it moves to FETCH, giving
    // one-cycle latency from run to inst_valid.
    load_c      = (state_q != S_HALTED) && run && (!inst_valid_q || inst_ready);
    last_addr_c = !WRAP_EN && (pc_q == PC_MAX);
    halt_hit_c  = (rom_data[INST_W-1 -: 4] == HALT_OP) || last_addr_c;

    if (redirect) begin
      // The word offered this cycle is dropped, so no count update here.
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      halted_d     = 1'b0;
      state_d      = run ? S_FETCH : S_IDLE;
    end else begin
      if (xfer_c && (fetch_count_q != CNT_MAX)) begin
        fetch_count_d = fetch_count_q + CNT_W'(1);
      end

      if (load_c) begin
        inst_d       = rom_data;
        inst_pc_d    = pc_q;
        inst_valid_d = 1'b1;
        // Without wrap the pc parks at the last address.
        pc_d         = last_addr_c ? pc_q : pc_q + ADDR_W'(1);
        state_d      = halt_hit_c ? S_HALTED : S_FETCH;
        halted_d     = halt_hit_c;
      end else begin
        if (xfer_c) begin
          inst_valid_d = 1'b0;
        end
        unique case (state_q)
          S_IDLE:   if (run)  state_d = S_FETCH;
          S_FETCH:  if (!run) state_d = S_IDLE;
          S_HALTED: state_d = S_HALTED;
          default:  state_d = S_IDLE;
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      inst_valid_q  <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rom_addr    = pc_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: instance 0 wraps the pc, instance 1 halts
// after the last address. Both see the same stimulus and the same ROM image.
module tb_instr_fetch_unit;

  localparam int unsigned AW = 3;
  localparam int unsigned IW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic run, inst_ready, redirect;
  logic [AW-1:0] redirect_pc;

  logic [IW-1:0] rom [8];

  logic [1:0][AW-1:0] rom_addr, inst_pc;
  logic [1:0][IW-1:0] rom_data, inst;
  logic [1:0]         inst_valid, halted;
  logic [1:0][15:0]   fetch_count;

  always #5 clk = ~clk;

  assign rom_data[0] = rom[rom_addr[0]];
  assign rom_data[1] = rom[rom_addr[1]];

  instr_fetch_unit #(.ADDR_W(AW), .INST_W(IW), .HALT_OP(4'b1110), .WRAP_EN(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .run(run), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
    .inst(inst[0]), .inst_pc(inst_pc[0]), .inst_valid(inst_valid[0]), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted[0]),
    .fetch_count(fetch_count[0])
  );

  instr_fetch_unit #(.ADDR_W(AW), .INST_W(IW), .HALT_OP(4'b1110), .WRAP_EN(1'b0)) u_nowrap (
    .clk(clk), .rst_n(rst_n), .run(run), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
    .inst(inst[1]), .inst_pc(inst_pc[1]), .inst_valid(inst_valid[1]), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted[1]),
    .fetch_count(fetch_count[1])
  );

  // Reference model: what the decoder sees, tracked per instance.
  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
    logic [AW-1:0] ipc;
    bit            valid;
    bit            halted;
    int            cnt;
  } mdl_t;

  mdl_t m [2];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic mdl_t mdl_next(mdl_t s, bit wrap);
    mdl_t n = s;
    bit xfer;
    logic [IW-1:0] w;
    if (redirect) begin
      n.pc = redirect_pc;
      n.valid = 1'b0;
      n.halted = 1'b0;
      return n;
    end
    xfer = s.valid && inst_ready;
    if (xfer && s.cnt < 65535) n.cnt = s.cnt + 1;
    if (!s.halted && run && (!s.valid || inst_ready)) begin
      w = rom[s.pc];
      n.inst = w;
      n.ipc = s.pc;
      n.valid = 1'b1;
      if (w[15:12] == 4'hE) n.halted = 1'b1;
      if (!wrap && s.pc == 3'd7) n.halted = 1'b1;
      else n.pc = AW'((s.pc + 1) % 8);
    end else if (xfer) begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 2; i++) m[i] = '{default: 0};
  endtask

  task automatic load_default_rom();
    rom[0] = 16'h1233; rom[1] = 16'h14EE; rom[2] = 16'hF201; rom[3] = 16'h3456;
    rom[4] = 16'h5A5A; rom[5] = 16'hF402; rom[6] = 16'h6789; rom[7] = 16'hF402;
  endtask

  // One clock: inputs are stable across the rising edge, outputs read at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      m[0] = mdl_next(m[0], 1'b1);
      m[1] = mdl_next(m[1], 1'b0);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    mdl_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({rom_addr[i], inst[i], inst_pc[i], inst_valid[i], halted[i], fetch_count[i]} !== '0) begin
        n_bad++;
        $display("FAIL reset[%0d]: addr=%h inst=%h pc=%h v=%b h=%b cnt=%0d, want all zero",
                 i, rom_addr[i], inst[i], inst_pc[i], inst_valid[i], halted[i], fetch_count[i]);
      end
    end
  endtask

  task automatic test_stream();
    logic [IW-1:0] exp_inst [3];
    exp_inst = '{16'h1233, 16'h14EE, 16'hF201};
    do_reset();
    run = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (inst_valid[0] !== 1'b1 || inst[0] !== exp_inst[k] || inst_pc[0] !== AW'(k) ||
          fetch_count[0] !== 16'(k)) begin
        n_bad++;
        $display("FAIL stream[%0d]: v=%b inst=%h pc=%0d cnt=%0d, want v=1 inst=%h pc=%0d cnt=%0d",
                 k, inst_valid[0], inst[0], inst_pc[0], fetch_count[0], exp_inst[k], k, k);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    run = 1'b1; inst_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (inst_valid[0] !== 1'b1 || inst[0] !== 16'h1233 || inst_pc[0] !== 3'd0 ||
          rom_addr[0] !== 3'd1 || fetch_count[0] !== 16'd0) begin
        n_bad++;
        $display("FAIL stall[%0d]: v=%b inst=%h pc=%0d addr=%0d cnt=%0d, want v=1 inst=1233 pc=0 addr=1 cnt=0",
                 k, inst_valid[0], inst[0], inst_pc[0], rom_addr[0], fetch_count[0]);
      end
      if (k == 0) inst_ready = 1'b0;
    end
    inst_ready = 1'b1;
    tick();
    n_cmp++;
    if (inst_valid[0] !== 1'b1 || inst[0] !== 16'h14EE || inst_pc[0] !== 3'd1 || fetch_count[0] !== 16'd1) begin
      n_bad++;
      $display("FAIL stall_resume1: v=%b inst=%h pc=%0d cnt=%0d, want v=1 inst=14ee pc=1 cnt=1",
               inst_valid[0], inst[0], inst_pc[0], fetch_count[0]);
    end
    tick();
    n_cmp++;
    if (inst_valid[0] !== 1'b1 || inst[0] !== 16'hF201 || inst_pc[0] !== 3'd2 || fetch_count[0] !== 16'd2) begin
      n_bad++;
      $display("FAIL stall_resume2: v=%b inst=%h pc=%0d cnt=%0d, want v=1 inst=f201 pc=2 cnt=2",
               inst_valid[0], inst[0], inst_pc[0], fetch_count[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (inst_valid[0] !== 1'b1 || inst_pc[0] !== AW'(k % 8) || inst[0] !== rom[k % 8] ||
          fetch_count[0] !== 16'(k) || halted[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL wrap[%0d]: v=%b pc=%0d inst=%h cnt=%0d h=%b, want v=1 pc=%0d inst=%h cnt=%0d h=0",
                 k, inst_valid[0], inst_pc[0], inst[0], fetch_count[0], halted[0], k % 8, rom[k % 8], k);
      end
      if (k == 7) begin
        n_cmp++;
        if (inst[0] !== 16'hF402) begin
          n_bad++;
          $display("FAIL wrap_pc7: inst=%h, want f402", inst[0]);
        end
      end
    end
  endtask

  task automatic test_nowrap();
    do_reset();
    run = 1'b1; inst_ready = 1'b1;
    repeat (8) tick();
    n_cmp++;
    if (halted[1] !== 1'b1 || inst_valid[1] !== 1'b1 || inst_pc[1] !== 3'd7 || inst[1] !== 16'hF402 ||
        rom_addr[1] !== 3'd7) begin
      n_bad++;
      $display("FAIL nowrap_last: h=%b v=%b pc=%0d inst=%h addr=%0d, want h=1 v=1 pc=7 inst=f402 addr=7",
               halted[1], inst_valid[1], inst_pc[1], inst[1], rom_addr[1]);
    end
    n_cmp++;
    if (halted[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_no_halt: h=%b, want 0", halted[0]);
    end
    repeat (2) begin
      tick();
      n_cmp++;
      if (halted[1] !== 1'b1 || inst_valid[1] !== 1'b0 || fetch_count[1] !== 16'd8) begin
        n_bad++;
        $display("FAIL nowrap_drain: h=%b v=%b cnt=%0d, want h=1 v=0 cnt=8",
                 halted[1], inst_valid[1], fetch_count[1]);
      end
    end
    redirect = 1'b1; redirect_pc = 3'd5;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (halted[1] !== 1'b0 || inst_valid[1] !== 1'b0 || rom_addr[1] !== 3'd5) begin
      n_bad++;
      $display("FAIL nowrap_redirect: h=%b v=%b addr=%0d, want h=0 v=0 addr=5",
               halted[1], inst_valid[1], rom_addr[1]);
    end
    tick();
    n_cmp++;
    if (inst_valid[1] !== 1'b1 || inst[1] !== 16'hF402 || inst_pc[1] !== 3'd5) begin
      n_bad++;
      $display("FAIL nowrap_restart: v=%b inst=%h pc=%0d, want v=1 inst=f402 pc=5",
               inst_valid[1], inst[1], inst_pc[1]);
    end
  endtask

  task automatic test_halt_op();
    rom[3] = 16'hE0A5;
    do_reset();
    run = 1'b1; inst_ready = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (halted[0] !== 1'b1 || inst_valid[0] !== 1'b1 || inst[0] !== 16'hE0A5 || rom_addr[0] !== 3'd4) begin
      n_bad++;
      $display("FAIL halt_op: h=%b v=%b inst=%h addr=%0d, want h=1 v=1 inst=e0a5 addr=4",
               halted[0], inst_valid[0], inst[0], rom_addr[0]);
    end
    repeat (2) begin
      tick();
      n_cmp++;
      if (halted[0] !== 1'b1 || inst_valid[0] !== 1'b0 || rom_addr[0] !== 3'd4 || fetch_count[0] !== 16'd4) begin
        n_bad++;
        $display("FAIL halt_hold: h=%b v=%b addr=%0d cnt=%0d, want h=1 v=0 addr=4 cnt=4",
                 halted[0], inst_valid[0], rom_addr[0], fetch_count[0]);
      end
    end
    load_default_rom();
  endtask

  task automatic test_redirect();
    do_reset();
    run = 1'b1; inst_ready = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (inst_valid[0] !== 1'b1 || inst[0] !== 16'h14EE || fetch_count[0] !== 16'd1) begin
      n_bad++;
      $display("FAIL redir_pre: v=%b inst=%h cnt=%0d, want v=1 inst=14ee cnt=1",
               inst_valid[0], inst[0], fetch_count[0]);
    end
    redirect = 1'b1; redirect_pc = 3'd2;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (inst_valid[0] !== 1'b0 || fetch_count[0] !== 16'd1 || rom_addr[0] !== 3'd2) begin
      n_bad++;
      $display("FAIL redir_flush: v=%b cnt=%0d addr=%0d, want v=0 cnt=1 addr=2",
               inst_valid[0], fetch_count[0], rom_addr[0]);
    end
    tick();
    n_cmp++;
    if (inst_valid[0] !== 1'b1 || inst[0] !== 16'hF201 || inst_pc[0] !== 3'd2 || fetch_count[0] !== 16'd1) begin
      n_bad++;
      $display("FAIL redir_target: v=%b inst=%h pc=%0d cnt=%0d, want v=1 inst=f201 pc=2 cnt=1",
               inst_valid[0], inst[0], inst_pc[0], fetch_count[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    run = 1'b1; inst_ready = 1'b1;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({rom_addr[i], inst[i], inst_pc[i], inst_valid[i], halted[i], fetch_count[i]} !== '0) begin
        n_bad++;
        $display("FAIL async_reset[%0d]: addr=%h inst=%h pc=%h v=%b h=%b cnt=%0d, want all zero",
                 i, rom_addr[i], inst[i], inst_pc[i], inst_valid[i], halted[i], fetch_count[i]);
      end
    end
    mdl_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (inst_valid[0] !== 1'b1 || inst[0] !== 16'h1233 || inst_pc[0] !== 3'd0 || fetch_count[0] !== 16'd0) begin
      n_bad++;
      $display("FAIL async_restart: v=%b inst=%h pc=%0d cnt=%0d, want v=1 inst=1233 pc=0 cnt=0",
               inst_valid[0], inst[0], inst_pc[0], fetch_count[0]);
    end
  endtask

  task automatic test_random();
    for (int a = 0; a < 8; a++) begin
      rom[a] = 16'($urandom);
      if ($urandom_range(3) == 0) rom[a][15:12] = 4'hE;
      else if (rom[a][15:12] == 4'hE) rom[a][15:12] = 4'h0;
    end
    do_reset();
    for (int c = 0; c < 600; c++) begin
      run = ($urandom_range(9) != 0);
      inst_ready = ($urandom_range(2) != 0);
      redirect = ($urandom_range(11) == 0);
      redirect_pc = AW'($urandom_range(7));
      tick();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (rom_addr[i] !== m[i].pc || inst_valid[i] !== m[i].valid || halted[i] !== m[i].halted ||
            fetch_count[i] !== 16'(m[i].cnt) ||
            (m[i].valid && (inst[i] !== m[i].inst || inst_pc[i] !== m[i].ipc))) begin
          n_bad++;
          $display("FAIL random[%0d] cyc %0d: addr=%0d v=%b h=%b cnt=%0d inst=%h pc=%0d; want addr=%0d v=%b h=%b cnt=%0d inst=%h pc=%0d",
                   i, c, rom_addr[i], inst_valid[i], halted[i], fetch_count[i], inst[i], inst_pc[i],
                   m[i].pc, m[i].valid, m[i].halted, m[i].cnt, m[i].inst, m[i].ipc);
        end
      end
    end
    load_default_rom();
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    load_default_rom();
    mdl_reset();
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_wrap();
    test_nowrap();
    test_halt_op();
    test_redirect();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
